// File: rtl/dual_roll_scheduler.sv
// Two-requester roll scheduler: round-robin grant, five phases of slowing LFSR steps, then final value capture.
// Latency: grant the cycle after a request is seen in IDLE; o_done 5*PHASE_CYC cycles after o_gnt rises.
// Backpressure: none; the owner drops i_req to abort. Define ROLL_RESTART_EN to add i_restart (owner restarts the roll).
module dual_roll_scheduler #(
    parameter logic [23:0] PHASE_CYC = 24'd10000000,
    parameter int          BASE_DIV  = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
`ifdef ROLL_RESTART_EN
    input  logic [1:0] i_restart,
`endif
    input  logic [3:0] i_rnd,
    output logic [1:0] o_gnt,
    output logic [1:0] o_done,
    output logic [3:0] o_value,
    output logic       o_step,
    output logic       o_busy,
    output logic [2:0] o_phase
);

    localparam logic [23:0] PHASE_LAST = PHASE_CYC - 24'd1;
    localparam logic [23:0] IV1_M1 = (PHASE_CYC >> BASE_DIV)       - 24'd1;
    localparam logic [23:0] IV2_M1 = (PHASE_CYC >> (BASE_DIV - 1)) - 24'd1;
    localparam logic [23:0] IV3_M1 = (PHASE_CYC >> (BASE_DIV - 2)) - 24'd1;
    localparam logic [23:0] IV4_M1 = (PHASE_CYC >> (BASE_DIV - 3)) - 24'd1;
    localparam logic [23:0] IV5_M1 = (PHASE_CYC >> (BASE_DIV - 4)) - 24'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        ptr;
    logic        owner;
    logic        gnt_sel;
    logic        restart_hit;
    logic [23:0] pcnt;
    logic [23:0] icnt;
    logic [23:0] icnt_nxt;
    logic [23:0] ival_m1;

`ifdef ROLL_RESTART_EN
    assign restart_hit = i_restart[owner];
`else
    assign restart_hit = 1'b0;
`endif

    // Both requesting: pointer decides; otherwise the lone requester wins.
    assign gnt_sel = (i_req == 2'b11) ? ptr : i_req[1];

    always_comb begin
        ival_m1 = '0;
        case (o_phase)
            3'd1:    ival_m1 = IV1_M1;
            3'd2:    ival_m1 = IV2_M1;
            3'd3:    ival_m1 = IV3_M1;
            3'd4:    ival_m1 = IV4_M1;
            3'd5:    ival_m1 = IV5_M1;
            default: ival_m1 = '0;
        endcase
    end

    // icnt counts down to the next step; zero means "step this cycle".
    assign icnt_nxt = (icnt == '0) ? ival_m1 : icnt - 24'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            o_gnt   <= '0;
            o_done  <= '0;
            o_value <= '0;
            o_step  <= 1'b0;
            o_busy  <= 1'b0;
            o_phase <= '0;
            pcnt    <= '0;
            icnt    <= '0;
        end else begin
            o_done <= '0;
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        state   <= ROLL;
                        owner   <= gnt_sel;
                        o_gnt   <= gnt_sel ? 2'b10 : 2'b01;
                        o_busy  <= 1'b1;
                        o_phase <= 3'd1;
                        o_step  <= 1'b1;
                        pcnt    <= '0;
                        icnt    <= '0;
                    end
                end
                ROLL: begin
                    if (!i_req[owner]) begin
                        state   <= IDLE;
                        ptr     <= ~owner;
                        o_gnt   <= '0;
                        o_busy  <= 1'b0;
                        o_phase <= '0;
                        o_step  <= 1'b0;
                        pcnt    <= '0;
                        icnt    <= '0;
                    end else if (restart_hit) begin
                        o_phase <= 3'd1;
                        o_step  <= 1'b1;
                        pcnt    <= '0;
                        icnt    <= '0;
                    end else if (pcnt == PHASE_LAST) begin
                        pcnt <= '0;
                        icnt <= '0;
                        if (o_phase == 3'd5) begin
                            state   <= DONE;
                            ptr     <= ~owner;
                            o_gnt   <= '0;
                            o_done  <= owner ? 2'b10 : 2'b01;
                            o_value <= i_rnd;
                            o_phase <= '0;
                            o_step  <= 1'b0;
                        end else begin
                            o_phase <= o_phase + 3'd1;
                            o_step  <= 1'b1;
                        end
                    end else begin
                        pcnt   <= pcnt + 24'd1;
                        icnt   <= icnt_nxt;
                        o_step <= (icnt_nxt == '0);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_gnt));
    a_step_busy:  assert property (@(posedge i_clk) disable iff (!i_rst_n) o_step |-> o_busy);

endmodule

// File: tb/tb_dual_roll_scheduler.sv
// Bench for dual_roll_scheduler (PHASE_CYC=64, BASE_DIV=5): directed scenarios plus random requests vs a timeline model.
module tb_dual_roll_scheduler;

    localparam int PC = 64;
    localparam int BD = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [3:0] rnd   = 4'h1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] value;
    logic       step;
    logic       busy;
    logic [2:0] phase;
`ifdef ROLL_RESTART_EN
    logic [1:0] restart = 2'b00;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 rolling, 2 done; m_t = cycles elapsed in the roll.
    int       m_mode  = 0;
    int       m_t     = 0;
    logic     m_owner = 1'b0;
    logic     m_ptr   = 1'b0;
    logic [3:0] m_value = 4'h0;

    dual_roll_scheduler #(
        .PHASE_CYC(24'd64),
        .BASE_DIV (5)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
`ifdef ROLL_RESTART_EN
        .i_restart(restart),
`endif
        .i_rnd    (rnd),
        .o_gnt    (gnt),
        .o_done   (done),
        .o_value  (value),
        .o_step   (step),
        .o_busy   (busy),
        .o_phase  (phase)
    );

    always #5 clk = ~clk;

    // Shared 4-bit LFSR datapath, advanced by o_step.
    always @(posedge clk) begin
        if (step) rnd <= {rnd[2:0], rnd[3] ^ rnd[2]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_t     = 0;
            m_owner = 1'b0;
            m_ptr   = 1'b0;
            m_value = 4'h0;
        end else begin
            case (m_mode)
                0: if (req != 2'b00) begin
                    m_owner = (req == 2'b11) ? m_ptr : req[1];
                    m_mode  = 1;
                    m_t     = 0;
                end
                1: begin
                    if (!req[m_owner]) begin
                        m_mode = 0;
                        m_ptr  = !m_owner;
                    end
`ifdef ROLL_RESTART_EN
                    else if (restart[m_owner]) m_t = 0;
`endif
                    else if (m_t == 5 * PC - 1) begin
                        m_mode  = 2;
                        m_value = rnd;
                        m_ptr   = !m_owner;
                    end else begin
                        m_t = m_t + 1;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int k;
        int ival;
        logic [1:0] oh;
        oh   = m_owner ? 2'b10 : 2'b01;
        k    = m_t / PC + 1;
        ival = PC >> (BD + 1 - k);
        check_eq("gnt",   32'(gnt),   (m_mode == 1) ? 32'(oh) : 32'd0);
        check_eq("done",  32'(done),  (m_mode == 2) ? 32'(oh) : 32'd0);
        check_eq("busy",  32'(busy),  32'(m_mode != 0));
        check_eq("phase", 32'(phase), (m_mode == 1) ? 32'(k) : 32'd0);
        check_eq("step",  32'(step),  32'((m_mode == 1) && (((m_t % PC) % ival) == 0)));
        check_eq("value", 32'(value), 32'(m_value));
    end

    initial begin
        int g, d, steps, n, k, first_done;
        logic [1:0] gv, dv, prevg;
        logic [1:0] gseq[3];
        int gcyc[3];
        logic [3:0] last_rnd;

        repeat (3) @(negedge clk);
        check_eq("rst_gnt", 32'(gnt), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_value", 32'(value), 0);
        check_eq("rst_step", 32'(step), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_phase", 32'(phase), 0);

        // Single requester held from reset release: full roll.
        rst_n = 1'b1;
        req   = 2'b01;
        g = -1; d = -1; steps = 0; gv = 0; dv = 0;
        for (int i = 0; i < 400 && d < 0; i++) begin
            @(negedge clk);
            if (step) steps++;
            if (g < 0 && gnt != 0) begin g = i; gv = gnt; end
            if (done != 0) begin
                d = i; dv = done;
                check_eq("full_value", 32'(value), 32'(rnd));
            end
        end
        req = 2'b00;
        check_eq("full_gnt", 32'(gv), 1);
        check_eq("full_steps", 32'(steps), 62);
        check_eq("full_latency", 32'(d - g), 320);
        check_eq("full_done", 32'(dv), 1);
        repeat (3) @(negedge clk);

        // Reset mid-roll at roll cycle 150.
        req = 2'b01;
        n = 0;
        for (int i = 0; i < 400 && n < 151; i++) begin
            @(negedge clk);
            if (gnt != 0) n++;
        end
        check_eq("rstmid_reached", 32'(n), 151);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_gnt", 32'(gnt), 0);
        check_eq("rstmid_busy", 32'(busy), 0);
        check_eq("rstmid_phase", 32'(phase), 0);
        check_eq("rstmid_step", 32'(step), 0);
        check_eq("rstmid_value", 32'(value), 0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (400) begin
            @(negedge clk);
            if (done != 0) n++;
        end
        check_eq("rstmid_no_done", 32'(n), 0);

        // Both requesting: 0, then 1 right after, then 0 again.
        req = 2'b11;
        k = 0; prevg = 0; first_done = -1; last_rnd = 0;
        for (int i = 0; i < 1200 && k < 3; i++) begin
            @(negedge clk);
            if (gnt != 0 && prevg == 0) begin gseq[k] = gnt; gcyc[k] = i; k++; end
            if (done != 0) begin
                last_rnd = rnd;
                if (first_done < 0) first_done = i;
            end
            prevg = gnt;
        end
        req = 2'b00;
        check_eq("rr_count", 32'(k), 3);
        check_eq("rr_first", 32'(gseq[0]), 1);
        check_eq("rr_second", 32'(gseq[1]), 2);
        check_eq("rr_third", 32'(gseq[2]), 1);
        check_eq("rr_regrant_gap", 32'(gcyc[1] - first_done), 2);
        repeat (3) @(negedge clk);

        // Owner abort at roll cycle 100.
        req = 2'b01;
        n = 0;
        for (int i = 0; i < 400 && n < 101; i++) begin
            @(negedge clk);
            if (gnt != 0) n++;
        end
        req = 2'b00;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_gnt", 32'(gnt), 0);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_value", 32'(value), 32'(last_rnd));
        req = 2'b11;
        gv = 0;
        for (int i = 0; i < 10 && gv == 0; i++) begin
            @(negedge clk);
            gv = gnt;
        end
        check_eq("abort_ptr", 32'(gv), 2);
        req = 2'b00;
        repeat (3) @(negedge clk);

`ifdef ROLL_RESTART_EN
        // Owner restart at roll cycle 200; a non-owner restart pulse later is ignored.
        req = 2'b01;
        n = 0;
        for (int i = 0; i < 400 && n < 201; i++) begin
            @(negedge clk);
            if (gnt != 0) n++;
        end
        restart = 2'b01;
        @(negedge clk);
        restart = 2'b00;
        check_eq("restart_phase", 32'(phase), 1);
        check_eq("restart_step", 32'(step), 1);
        d = -1;
        for (int i = 1; i < 400 && d < 0; i++) begin
            @(negedge clk);
            restart = (i == 5) ? 2'b10 : 2'b00;
            if (done != 0) d = i;
        end
        restart = 2'b00;
        req = 2'b00;
        check_eq("restart_latency", 32'(d), 320);
        repeat (3) @(negedge clk);
`endif

        // Random requests, occasional resets (and restarts when enabled).
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if ($urandom_range(799) == 0) req[0] = ~req[0];
            if ($urandom_range(799) == 0) req[1] = ~req[1];
`ifdef ROLL_RESTART_EN
            restart = ($urandom_range(199) == 0) ? 2'($urandom_range(3)) : 2'b00;
`endif
            if ($urandom_range(7999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
